// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types, used by the register file, ALU,
// control unit and datapath top.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  function automatic logic is_zero_reg(input reg_addr_t addr);
    return addr == reg_addr_t'(REG_ZERO);
  endfunction

endpackage

// File: rtl/mips_regfile_rdport.sv
// One combinational read port: forces $zero to 0 and, when REGFILE_BYPASS_EN
// is defined, forwards the same-cycle write data to the reader.
module mips_regfile_rdport
  import mips_pkg::*;
#(
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int ADDR_W   = mips_pkg::ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic [ADDR_W-1:0]               i_addr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0] i_regs,
  input  logic                            i_rst,
  input  logic                            i_reg_write,
  input  logic [ADDR_W-1:0]               i_wr_addr,
  input  logic [DATA_W-1:0]               i_wr_data,
  output logic [DATA_W-1:0]               o_data
);

`ifdef REGFILE_BYPASS_EN
  logic w_fwd;
  assign w_fwd = i_reg_write && !i_rst && (i_wr_addr == i_addr);

  always_comb begin
    o_data = i_regs[i_addr];
    if (w_fwd) o_data = i_wr_data;
    // $zero beats forwarding
    if (i_addr == '0) o_data = '0;
  end
`else
  logic w_unused;
  assign w_unused = i_rst ^ i_reg_write ^ (^i_wr_addr) ^ (^i_wr_data);

  always_comb begin
    o_data = i_regs[i_addr];
    if (i_addr == '0) o_data = '0;
  end
`endif

endmodule

// File: rtl/mips_regfile.sv
// 32 x 32 MIPS register file: two combinational read ports, one synchronous
// write port, $zero hardwired. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module mips_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  // Slot 0 of the view is a constant; only r1..r31 have flops behind them.
  logic [NUM_REGS-1:0][DATA_W-1:0] w_regs;
  assign w_regs[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] r_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_q <= '0;
        end else if (reg_write && (wr_addr == ADDR_W'(gi))) begin
          r_q <= wr_data;
        end
      end

      assign w_regs[gi] = r_q;
    end
  endgenerate

  mips_regfile_rdport #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_rdport_rs (
    .i_addr     (rs_addr),
    .i_regs     (w_regs),
    .i_rst      (rst),
    .i_reg_write(reg_write),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .o_data     (rs_data)
  );

  mips_regfile_rdport #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_rdport_rt (
    .i_addr     (rt_addr),
    .i_regs     (w_regs),
    .i_rst      (rst),
    .i_reg_write(reg_write),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .o_data     (rt_data)
  );

endmodule

// File: doc/mips_regfile.md
Name: mips_regfile

Overview:
- 32 x 32-bit MIPS general-purpose register file; the stage directly upstream of the ALU.
- Two combinational read ports drive the ALU operands: rs_data feeds inp_1, and rt_data feeds the ALUSrc mux that produces inp_2.
- One synchronous write port takes the writeback result, either aluout or memory load data selected by the MemtoReg mux.
- $zero is hardwired to 0.

Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W (32)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- rs_addr  input  ADDR_W  read port A address (instr[25:21])
- rt_addr  input  ADDR_W  read port B address (instr[20:16])
- wr_addr  input  ADDR_W  write address (RegDst-selected rt/rd)
- wr_data  input  DATA_W  writeback data
- reg_write  input  1  write enable (RegWrite)
- rs_data  output  DATA_W  read port A data, to ALU inp_1
- rt_data  output  DATA_W  read port B data, to ALUSrc mux / store data

Behaviour:
- Storage: NUM_REGS-1 flops of DATA_W bits for r1..r31. r0 is not stored.
- Reset:
  - When rst=1 at a rising clk edge, every stored register becomes 0.
  - From the next cycle on, rs_data=0 and rt_data=0 for every address.
  - Reset takes priority over reg_write in the same cycle: the write is dropped.
  - Reset asserted in the middle of a program clears all registers regardless of pending writes.
- Write:
  - On a rising clk edge with rst=0, reg_write=1 and wr_addr!=0: reg[wr_addr] <= wr_data.
  - Writes to address 0 are silently discarded.
  - reg_write=0 means no state change.
- Read:
  - Purely combinational, zero latency.
  - rs_data = (rs_addr==0) ? 0 : reg[rs_addr]; rt_data likewise.
  - The read-port output is always 0 for address 0, even though no r0 flop exists.
- Read-during-write to the same address, without bypass: the read returns the old (pre-edge) value. The new value is visible from the cycle after the edge. This is the single-cycle contract: the instruction writes back at the end of its own cycle.
- Both read ports may address the same register; both return the identical value.
- wr_data and the addresses are unconstrained full-width values; there is no sign handling.
- No X on outputs after the first reset; before any reset, contents are undefined.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. If reg_write=1, rst=0, wr_addr!=0 and rs_addr==wr_addr, then rs_data=wr_data combinationally in the same cycle; rt_data likewise. The r0 rule still wins, and rst=1 suppresses forwarding. This is needed when the block is reused behind a pipelined writeback.
- Not defined: the plain old-value behaviour described above. No bypass muxes are synthesised.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W and ADDR_W constants
  - register index constants REG_ZERO=0, REG_SP=29, REG_RA=31
  - the reg_addr_t and word_t typedefs, reused by the ALU, control unit and datapath top
- One natural sub-module, mips_regfile_rdport:
  - inputs: address, storage array view, write-side signals
  - applies the zero rule and the optional bypass
  - instantiated twice, once per read port.

Test Plan:
- Reset sweep: preload r1..r31 with 0xA5A5_0000+i, assert rst for one cycle, then read every address on both ports -> all 0.
- Basic write/read: write r8=0xDEADBEEF, next cycle rs_addr=8, rt_addr=8 -> both ports 0xDEADBEEF; r9 still 0.
- Zero register: reg_write=1, wr_addr=0, wr_data=0xFFFFFFFF, then read address 0 -> 0.
- Same-cycle read/write of r5, old value 0x11, new value 0x22:
  - macro undefined: read 0x11 in the write cycle, 0x22 in the next cycle.
  - REGFILE_BYPASS_EN defined: 0x22 in the write cycle.
- Reset vs write collision: rst=1, reg_write=1, wr_addr=31, wr_data=0x1234 -> r31 reads 0 after the edge.
- Back-to-back writes: r3=7, then r3=9, reg_write held -> r3 reads 7 after the first edge and 9 after the second. rs_addr=3 and rt_addr=4 read concurrently, with r4 unchanged.
